// File: rtl/filter_cutoff_env.sv
// Gated ADSR envelope mapped linearly onto [f_min, f_max] to drive filter_svf.F (1.0 = 2^17).
// Optional FILTER_CUTOFF_ENV_INVERT_EN adds an 'invert' input that sweeps downward from f_max.
module filter_cutoff_env #(
   parameter int ENV_WIDTH = 16,
   parameter int F_WIDTH   = 18
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick,
   input  logic                 gate,
`ifdef FILTER_CUTOFF_ENV_INVERT_EN
   input  logic                 invert,
`endif
   input  logic [ENV_WIDTH-1:0] attack_rate,
   input  logic [ENV_WIDTH-1:0] decay_rate,
   input  logic [ENV_WIDTH-1:0] release_rate,
   input  logic [ENV_WIDTH-1:0] sustain,
   input  logic [F_WIDTH-1:0]   f_min,
   input  logic [F_WIDTH-1:0]   f_max,
   output logic [F_WIDTH-1:0]   F,
   output logic [ENV_WIDTH-1:0] env,
   output logic [2:0]           state,
   output logic                 active
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ATTACK  = 3'd1,
      DECAY   = 3'd2,
      SUSTAIN = 3'd3,
      RELEASE = 3'd4
   } state_e;

   localparam logic [ENV_WIDTH-1:0] ENV_MAX = '1;

   state_e                       state_q, state_d;
   logic [ENV_WIDTH-1:0]         env_q, env_d;
   logic [F_WIDTH-1:0]           f_q, f_d;

   logic [ENV_WIDTH:0]           attack_sum;
   logic [ENV_WIDTH:0]           decay_floor;
   logic [ENV_WIDTH-1:0]         att_env, rel_env;
   state_e                       att_state, rel_state;
   logic                         range_ok;
   logic [F_WIDTH-1:0]           span, scaled;
   logic [F_WIDTH+ENV_WIDTH-1:0] prod;

   // Attack and release outcomes are shared by the stage rules and the gate-priority paths.
   always_comb begin
      attack_sum  = {1'b0, env_q} + {1'b0, attack_rate};
      decay_floor = {1'b0, sustain} + {1'b0, decay_rate};

      att_env   = attack_sum[ENV_WIDTH-1:0];
      att_state = ATTACK;
      if (attack_rate == '0 || attack_sum >= {1'b0, ENV_MAX}) begin
         att_env   = ENV_MAX;
         att_state = DECAY;
      end

      rel_env   = env_q - release_rate;
      rel_state = RELEASE;
      if (release_rate == '0 || env_q <= release_rate) begin
         rel_env   = '0;
         rel_state = IDLE;
      end

      state_d = state_q;
      env_d   = env_q;
      if (tick) begin
         case (state_q)
            IDLE: begin
               env_d = '0;
               if (gate) state_d = ATTACK;
            end
            ATTACK: begin
               if (!gate) begin
                  env_d   = rel_env;
                  state_d = rel_state;
               end else begin
                  env_d   = att_env;
                  state_d = att_state;
               end
            end
            DECAY: begin
               if (!gate) begin
                  env_d   = rel_env;
                  state_d = rel_state;
               end else if (decay_rate == '0 || {1'b0, env_q} <= decay_floor) begin
                  env_d   = sustain;
                  state_d = SUSTAIN;
               end else begin
                  env_d = env_q - decay_rate;
               end
            end
            SUSTAIN: begin
               if (!gate) begin
                  env_d   = rel_env;
                  state_d = rel_state;
               end else begin
                  env_d = sustain;
               end
            end
            RELEASE: begin
               if (gate) begin
                  env_d   = att_env;
                  state_d = att_state;
               end else begin
                  env_d   = rel_env;
                  state_d = rel_state;
               end
            end
            default: begin
               env_d   = '0;
               state_d = IDLE;
            end
         endcase
      end
   end

   // A reversed range collapses span to zero, so both mappings pin F at f_min.
   always_comb begin
      range_ok = (f_max >= f_min);
      span     = range_ok ? (f_max - f_min) : '0;
      prod     = {{ENV_WIDTH{1'b0}}, span} * {{F_WIDTH{1'b0}}, env_q};
      scaled   = F_WIDTH'(prod >> ENV_WIDTH);
      f_d      = f_min + scaled;
`ifdef FILTER_CUTOFF_ENV_INVERT_EN
      if (invert && range_ok) f_d = f_max - scaled;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         env_q   <= '0;
         f_q     <= '0;
      end else begin
         state_q <= state_d;
         env_q   <= env_d;
         f_q     <= f_d;
      end
   end

   assign F      = f_q;
   assign env    = env_q;
   assign state  = state_q;
   assign active = (state_q != IDLE);

endmodule

// File: doc/filter_cutoff_env.md
# filter_cutoff_env

Cutoff-modulation envelope feeding the `F` coefficient input of `filter_svf`. It runs a gated ADSR state machine on an internal 16-bit envelope level, advancing once per sample tick. The level is mapped linearly onto a programmable range `[f_min, f_max]` to produce a registered 18-bit cutoff word. The word uses the filter's F scaling, where 1.0 = 2^17. It sits between the voice/gate logic and the filter.

## Interface
Parameters:
- `ENV_WIDTH`, 16 — envelope accumulator width; the mapping below assumes 16.
- `F_WIDTH`, 18 — cutoff word width, unsigned, 1.0 = 2^17.

Ports:
- `clk` in 1 — system clock.
- `rst` in 1 — reset; synchronous, active-high.
- `tick` in 1 — sample strobe; the envelope advances only on cycles with `tick`=1.
- `gate` in 1 — note gate, level-sensitive, sampled on tick cycles.
- `attack_rate` in 16 — increment per tick in ATTACK; 0 = instant.
- `decay_rate` in 16 — decrement per tick in DECAY; 0 = instant.
- `release_rate` in 16 — decrement per tick in RELEASE; 0 = instant.
- `sustain` in 16 — sustain level.
- `f_min` in 18 — cutoff at envelope 0.
- `f_max` in 18 — cutoff at envelope 65535.
- `F` out 18 — cutoff coefficient to `filter_svf.F`.
- `env` out 16 — current envelope level.
- `state` out 3 — IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- `active` out 1 — high when `state` is not IDLE.

## Operation
- Evaluation happens only on cycles with `tick`=1. Off-tick, `state` and `env` hold.
- IDLE:
  - `env`=0.
  - `gate`=1 → ATTACK; `env` is unchanged this tick.
- ATTACK:
  - `env` += `attack_rate`, saturating at 65535. At saturation → DECAY.
  - `attack_rate`=0 → `env`=65535 and → DECAY on the same tick.
- DECAY:
  - If `env` − `decay_rate` ≤ `sustain` (computed without wrap), then `env`=`sustain` → SUSTAIN.
  - Otherwise `env` −= `decay_rate`.
  - `decay_rate`=0 → instant jump to `sustain`.
- SUSTAIN: `env` tracks `sustain` every tick, including live changes.
- RELEASE:
  - `env` −= `release_rate`, floored at 0. On reaching 0 → IDLE.
  - `release_rate`=0 → `env`=0 → IDLE.
- Gate priority, checked before the stage rules on the same tick:
  - `gate`=0 in ATTACK, DECAY or SUSTAIN → RELEASE; the release decrement is applied on that tick.
  - `gate`=1 in RELEASE → ATTACK (retrigger from current `env`, no reset to 0); the attack increment is applied on that tick.
- `sustain`=65535: DECAY completes on its first tick.
- Mapping:
  - `span` = (`f_max` ≥ `f_min`) ? `f_max`−`f_min` : 0.
  - `prod` = `span` × `env` (34-bit).
  - `F` = `f_min` + `prod[33:16]`.
  - `F` never exceeds `max(f_min, f_max)`.
  - Reversed range (`f_min` > `f_max`) yields `F`=`f_min` constantly.

## Timing
- Reset (`rst`=1 at a clock edge):
  - `state`=IDLE, `env`=0, `F`=0, `active`=0.
  - Reset overrides `tick` and `gate` on the same edge.
  - Mid-envelope reset aborts to IDLE immediately.
- `state`/`env` update on the edge where `tick`=1.
- `F` is registered: it reflects `env`, `f_min` and `f_max` as they were one cycle earlier.
  - First cycle after reset release: `F`=`f_min`.
- `tick` held high continuously advances the envelope every cycle; this is legal.
- `gate` pulses entirely between ticks are not seen; by design, no latching.
- `active` is combinational from `state`.

## Configuration
- `FILTER_CUTOFF_ENV_INVERT_EN` defined:
  - Adds input `invert` (1 bit).
  - When `invert`=1, `F` = `f_max` − `prod[33:16]`, i.e. the sweep runs downward from `f_max`.
  - When `invert`=0, the normal mapping applies.
  - For a reversed range, `F`=`f_min` regardless of `invert`.
- Macro undefined: no `invert` port; normal mapping only.

## Test plan
- Reset then idle, `f_min`=1000, `f_max`=50000: `F`=0 during reset, `F`=1000 one cycle after release; `state`=0, `active`=0.
- Full ADSR, `tick` every cycle, attack=16384, decay=8192, sustain=32768, release=4096:
  - `gate`=1 → `env` 0, 16384, 32768, 49152, 65535 (DECAY).
  - Then 57343, 49151, 40959, 32768 (SUSTAIN).
  - `gate`=0 → 28672 … 0 after 8 release ticks → IDLE.
  - `F` = 1000 + (49000·`env`)>>16, one cycle after each `env` value.
- Instant rates, all rates 0, sustain=20000: one tick each gives 65535, then 20000; `gate`=0 → 0 → IDLE on one tick.
- Retrigger: `gate`=0 at `env`=40000 in SUSTAIN (sustain=40000, release=1000) → 39000; `gate`=1 on the next tick with attack=10000 → 49000 in ATTACK (not 10000).
- Boundary checks:
  - `f_min`=60000, `f_max`=10000 → `F`=60000 for all `env`.
  - `tick` held low for 100 cycles with `gate`=1 → `state` stays IDLE.
  - `rst` asserted during ATTACK → IDLE, `env`=0 next cycle.
- With `FILTER_CUTOFF_ENV_INVERT_EN`, `invert`=1, `f_min`=0, `f_max`=65536, `env`=65535 → `F`=1.
